// File: rtl/rr_select_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 data-selector index, with burst
// limiting and a valid/ready handshake. Optional `RR_ARB_LOCK_EN adds a lock input.
module rr_select_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       valid,
    output logic       last,
    output logic       state_dbg
);

    // Handshake: a beat transfers on every cycle where valid && ready; valid
    // holds with select fixed while ready is low, and select only changes when
    // a grant starts.

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [7:0] BEAT_MAX = 8'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] select_n;
    logic [3:0] grant_n;
    logic [7:0] beat, beat_n;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic       lock_act;
    logic       xfer;

`ifdef RR_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign state_dbg = (state == GRANT);
    assign valid     = (state == GRANT) && req[select];
    assign last      = valid && !lock_act && (beat == BEAT_MAX);
    assign xfer      = valid && ready;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_idx = ptr;
        idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) win_idx = idx;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        select_n = select;
        grant_n  = grant;
        beat_n   = beat;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_n  = GRANT;
                    select_n = win_idx;
                    grant_n  = 4'b0001 << win_idx;
                    beat_n   = 8'd0;
                end
            end
            GRANT: begin
                if (!req[select] || (xfer && last)) begin
                    state_n = IDLE;
                    ptr_n   = select + 2'd1;
                    grant_n = 4'b0000;
                    beat_n  = 8'd0;
                end else if (xfer && (beat != BEAT_MAX)) begin
                    // Under lock the counter parks at BEAT_MAX so the first
                    // transfer after lock drops is the releasing one.
                    beat_n = beat + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            select <= 2'd0;
            grant  <= 4'b0000;
            beat   <= 8'd0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            select <= select_n;
            grant  <= grant_n;
            beat   <= beat_n;
        end
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: a HOLD_MAX=2 instance plus a HOLD_MAX=1
// instance, a per-cycle vector table and hand-written multi-cycle sequences.
module tb_rr_select_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lock = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;

    logic [1:0] select, select1;
    logic [3:0] grant, grant1;
    logic       valid, valid1, last, last1, dbg, dbg1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_select_arbiter #(.HOLD_MAX(2)) dut (
        .clk(clk), .reset(reset),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req), .ready(ready), .select(select), .grant(grant),
        .valid(valid), .last(last), .state_dbg(dbg)
    );

    rr_select_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .reset(reset),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req), .ready(ready), .select(select1), .grant(grant1),
        .valid(valid1), .last(last1), .state_dbg(dbg1)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] rq;
        logic       rdy;
        logic       v;  logic [1:0] s;  logic [3:0] g;  logic l;
        logic       v1; logic [1:0] s1; logic [3:0] g1; logic l1;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, compare outputs 1 ns later.
    task automatic step(input string tag, input int cyc, input logic r, input logic [3:0] rq,
                        input logic rd, input logic lk, input logic ev, input logic [1:0] es,
                        input logic [3:0] eg, input logic el);
        @(negedge clk);
        reset = r; req = rq; ready = rd; lock = lk;
        #1;
        chk({tag, ".valid"},  cyc, {3'b0, valid}, {3'b0, ev});
        chk({tag, ".select"}, cyc, {2'b0, select}, {2'b0, es});
        chk({tag, ".grant"},  cyc, grant, eg);
        chk({tag, ".last"},   cyc, {3'b0, last}, {3'b0, el});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 4'b0000; ready = 1'b0; lock = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //            rst  req    rdy  v  s  g     l   v1 s1 g1    l1
        tbl[0]  = '{1'b1, 4'hf, 1'b1, 0, 0, 4'h0, 0,  0, 0, 4'h0, 0};
        tbl[1]  = '{1'b1, 4'hf, 1'b1, 0, 0, 4'h0, 0,  0, 0, 4'h0, 0};
        tbl[2]  = '{1'b0, 4'hf, 1'b1, 0, 0, 4'h0, 0,  0, 0, 4'h0, 0};
        tbl[3]  = '{1'b0, 4'hf, 1'b1, 1, 0, 4'h1, 0,  1, 0, 4'h1, 1};
        tbl[4]  = '{1'b0, 4'hf, 1'b1, 1, 0, 4'h1, 1,  0, 0, 4'h0, 0};
        tbl[5]  = '{1'b0, 4'hf, 1'b1, 0, 0, 4'h0, 0,  1, 1, 4'h2, 1};
        tbl[6]  = '{1'b0, 4'hf, 1'b1, 1, 1, 4'h2, 0,  0, 1, 4'h0, 0};
        tbl[7]  = '{1'b0, 4'hf, 1'b1, 1, 1, 4'h2, 1,  1, 2, 4'h4, 1};
        tbl[8]  = '{1'b0, 4'hf, 1'b1, 0, 1, 4'h0, 0,  0, 2, 4'h0, 0};
        tbl[9]  = '{1'b0, 4'hf, 1'b1, 1, 2, 4'h4, 0,  1, 3, 4'h8, 1};
        tbl[10] = '{1'b0, 4'hf, 1'b1, 1, 2, 4'h4, 1,  0, 3, 4'h0, 0};
        tbl[11] = '{1'b0, 4'hf, 1'b1, 0, 2, 4'h0, 0,  1, 0, 4'h1, 1};
        tbl[12] = '{1'b0, 4'hf, 1'b1, 1, 3, 4'h8, 0,  0, 0, 4'h0, 0};
        tbl[13] = '{1'b0, 4'hf, 1'b1, 1, 3, 4'h8, 1,  1, 1, 4'h2, 1};
        tbl[14] = '{1'b0, 4'hf, 1'b1, 0, 3, 4'h0, 0,  0, 1, 4'h0, 0};
        tbl[15] = '{1'b0, 4'hf, 1'b1, 1, 0, 4'h1, 0,  1, 2, 4'h4, 1};

        @(posedge clk);

        // Reset defaults, rotation with HOLD_MAX=2, every-beat-last with HOLD_MAX=1.
        for (int i = 0; i < 16; i++) begin
            step("rot", i, tbl[i].rst, tbl[i].rq, tbl[i].rdy, 1'b0,
                 tbl[i].v, tbl[i].s, tbl[i].g, tbl[i].l);
            chk("h1.valid",  i, {3'b0, valid1}, {3'b0, tbl[i].v1});
            chk("h1.select", i, {2'b0, select1}, {2'b0, tbl[i].s1});
            chk("h1.grant",  i, grant1, tbl[i].g1);
            chk("h1.last",   i, {3'b0, last1}, {3'b0, tbl[i].l1});
        end

        // Backpressure on source 2: stalled cycles do not advance the beat count.
        do_reset();
        step("bp", 0, 1'b0, 4'b0100, 1'b0, 1'b0, 0, 2'd0, 4'h0, 0);
        for (int i = 1; i <= 5; i++)
            step("bp", i, 1'b0, 4'b0100, 1'b0, 1'b0, 1, 2'd2, 4'h4, 0);
        step("bp", 6, 1'b0, 4'b0100, 1'b1, 1'b0, 1, 2'd2, 4'h4, 0);
        step("bp", 7, 1'b0, 4'b0100, 1'b1, 1'b0, 1, 2'd2, 4'h4, 1);
        step("bp", 8, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 2'd2, 4'h0, 0);

        // Request drop on source 1 after one beat; ptr=2 skips idle source 2 to reach 3.
        do_reset();
        step("drop", 0, 1'b0, 4'b0010, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0);
        step("drop", 1, 1'b0, 4'b1010, 1'b1, 1'b0, 1, 2'd1, 4'h2, 0);
        step("drop", 2, 1'b0, 4'b1000, 1'b1, 1'b0, 0, 2'd1, 4'h2, 0);
        step("drop", 3, 1'b0, 4'b1000, 1'b1, 1'b0, 0, 2'd1, 4'h0, 0);
        step("drop", 4, 1'b0, 4'b1000, 1'b1, 1'b0, 1, 2'd3, 4'h8, 0);

        // Reset mid-grant: move ptr to 2 first, so source 0 winning afterwards shows ptr cleared.
        do_reset();
        step("rst", 0, 1'b0, 4'b0010, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0);
        step("rst", 1, 1'b0, 4'b0010, 1'b1, 1'b0, 1, 2'd1, 4'h2, 0);
        step("rst", 2, 1'b0, 4'b0010, 1'b1, 1'b0, 1, 2'd1, 4'h2, 1);
        step("rst", 3, 1'b0, 4'b0001, 1'b1, 1'b0, 0, 2'd1, 4'h0, 0);
        step("rst", 4, 1'b0, 4'b0001, 1'b1, 1'b0, 1, 2'd0, 4'h1, 0);
        step("rst", 5, 1'b1, 4'b1111, 1'b1, 1'b0, 1, 2'd0, 4'h1, 1);
        step("rst", 6, 1'b0, 4'b1111, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0);
        step("rst", 7, 1'b0, 4'b1111, 1'b1, 1'b0, 1, 2'd0, 4'h1, 0);

`ifdef RR_ARB_LOCK_EN
        // Lock holds source 0 past the beat limit; first transfer after unlock releases.
        do_reset();
        step("lock", 0, 1'b0, 4'b0011, 1'b1, 1'b1, 0, 2'd0, 4'h0, 0);
        for (int i = 1; i <= 6; i++)
            step("lock", i, 1'b0, 4'b0011, 1'b1, 1'b1, 1, 2'd0, 4'h1, 0);
        step("lock", 7, 1'b0, 4'b0011, 1'b1, 1'b0, 1, 2'd0, 4'h1, 1);
        step("lock", 8, 1'b0, 4'b0011, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0);
        step("lock", 9, 1'b0, 4'b0011, 1'b1, 1'b0, 1, 2'd1, 4'h2, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
